// File: rtl/gold_pkg.sv
// Shared state type, default tap constants and counter-width helper
// for the gold-code A-branch receive checker.
package gold_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } gold_state_t;

    localparam int GOLD_CYCLE_A0 = 26;
    localparam int GOLD_CYCLE_A3 = 4;

    // Bits needed to hold every value from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gold_chk_lfsr.sv
// Local replica of the A-branch generator: loads received chips while
// acquiring, then free-runs on its own prediction as a flywheel.
module gold_chk_lfsr
    import gold_pkg::*;
#(
    parameter int CYCLE_A0 = GOLD_CYCLE_A0,
    parameter int CYCLE_A3 = GOLD_CYCLE_A3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_shift,
    input  logic i_load,
    input  logic i_din,
    output logic o_pred
);

    logic [CYCLE_A0-1:0] r_sr;
    logic                w_in;

    // Bit 0 holds the newest chip, so the taps sit at CYCLE_A3-1 and CYCLE_A0-1.
    assign o_pred = r_sr[CYCLE_A3-1] ^ r_sr[CYCLE_A0-1];
    assign w_in   = i_load ? i_din : o_pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_shift) begin
            r_sr <= {r_sr[CYCLE_A0-2:0], w_in};
        end
    end

endmodule

// File: rtl/gold_chk_a.sv
// Gold-code A-branch receive checker: acquire, verify, hold lock and count errors.
// Optional feature macro GOLD_CHK_ERR_CNT_EN enables the saturating Err_Count.
module gold_chk_a
    import gold_pkg::*;
#(
    parameter int CYCLE_A0   = GOLD_CYCLE_A0,
    parameter int CYCLE_A3   = GOLD_CYCLE_A3,
    parameter int VERIFY_LEN = 32,
    parameter int WIN_LEN    = 64,
    parameter int ERR_THR    = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Data_In,
    input  logic             Resync,
    output logic             Locked,
    output logic             Chip_Err,
    output logic [CNT_W-1:0] Err_Count
);

    localparam int FILL_W  = cnt_width(CYCLE_A0);
    localparam int MATCH_W = cnt_width(VERIFY_LEN);
    localparam int WIN_W   = cnt_width(WIN_LEN);
    localparam int WERR_W  = cnt_width(ERR_THR);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(CYCLE_A0 - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(VERIFY_LEN - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  ERR_LIMIT  = WERR_W'(ERR_THR);

    gold_state_t        r_state;
    logic [FILL_W-1:0]  r_fill_cnt;
    logic [MATCH_W-1:0] r_match_cnt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [WERR_W-1:0]  r_win_err;
    logic               r_locked;
    logic               r_chip_err;

    logic               w_pred;
    logic               w_mismatch;
    logic               w_shift;
    logic               w_load;
    logic [WERR_W-1:0]  w_win_err_next;

    assign w_mismatch     = Data_In ^ w_pred;
    assign w_load         = (r_state == ACQ);
    assign w_win_err_next = r_win_err + WERR_W'(w_mismatch);

    // A mismatching chip in VERIFY is discarded so the predictor is not polluted.
    assign w_shift = Enable && !Resync &&
                     ((r_state == ACQ) || (r_state == LOCKED) ||
                      ((r_state == VERIFY) && !w_mismatch));

    gold_chk_lfsr #(
        .CYCLE_A0 (CYCLE_A0),
        .CYCLE_A3 (CYCLE_A3)
    ) u_lfsr (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .i_shift (w_shift),
        .i_load  (w_load),
        .i_din   (Data_In),
        .o_pred  (w_pred)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ACQ;
            r_fill_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_chip_err  <= 1'b0;
        end else if (Resync) begin
            r_state     <= ACQ;
            r_fill_cnt  <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_chip_err  <= 1'b0;
        end else if (Enable) begin
            case (r_state)
                ACQ: begin
                    r_chip_err <= 1'b0;
                    if (r_fill_cnt == FILL_LAST) begin
                        r_state     <= VERIFY;
                        r_fill_cnt  <= '0;
                        r_match_cnt <= '0;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    r_chip_err <= w_mismatch;
                    if (w_mismatch) begin
                        r_state     <= ACQ;
                        r_fill_cnt  <= '0;
                        r_match_cnt <= '0;
                    end else if (r_match_cnt == MATCH_LAST) begin
                        r_state     <= LOCKED;
                        r_locked    <= 1'b1;
                        r_match_cnt <= '0;
                        r_win_cnt   <= '0;
                        r_win_err   <= '0;
                    end else begin
                        r_match_cnt <= r_match_cnt + MATCH_W'(1);
                    end
                end
                LOCKED: begin
                    r_chip_err <= w_mismatch;
                    // Threshold check comes first so it wins over the end-of-window clear.
                    if (w_win_err_next == ERR_LIMIT) begin
                        r_state     <= ACQ;
                        r_locked    <= 1'b0;
                        r_fill_cnt  <= '0;
                        r_match_cnt <= '0;
                        r_win_cnt   <= '0;
                        r_win_err   <= '0;
                    end else if (r_win_cnt == WIN_LAST) begin
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + WIN_W'(1);
                        r_win_err <= w_win_err_next;
                    end
                end
                default: begin
                    r_state  <= ACQ;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign Locked   = r_locked;
    assign Chip_Err = r_chip_err;

`ifdef GOLD_CHK_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_count;

    // Survives loss of lock so the BER monitor sees a running total.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_err_count <= '0;
        end else if (Resync) begin
            r_err_count <= '0;
        end else if (Enable && (r_state == LOCKED) && w_mismatch && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign Err_Count = r_err_count;
`else
    assign Err_Count = '0;
`endif

endmodule
